pwm_capture: RTL

Measures an incoming PWM waveform and reports its period and high time in `clk` cycles. It is the receive-side counterpart to the PWM generator and shares its 16-bit count domain. Typical uses are loopback checking of generator output and reading external PWM sources. Results are published through a valid/ack register handshake to the register file, and a timeout flag reports a stuck line (0% or 100% duty).

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_in_sync.sv | 72 +++++++
 rtl/pwm_capture.sv | 114 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: count width,
// synchronizer depth floor and the capture FSM state type.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W       = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: synchronizer chain, optional glitch filter
// (PWM_CAPTURE_FILTER_EN) and single-cycle rise/fall pulses.
module pwm_in_sync
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned STAGES =
        (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_s_d;
    logic              w_raw;
    logic              w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pwm};
        end
    end

    assign w_raw = r_sync[STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] r_hist;
    logic       r_held;

    // Level follows the raw line only once three consecutive samples agree;
    // the decision is combinational so both edges gain exactly two cycles.
    always_comb begin
        w_s = r_held;
        if ((w_raw == r_hist[0]) && (w_raw == r_hist[1])) begin
            w_s = w_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_held <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_raw};
            r_held <= w_s;
        end
    end
`else
    assign w_s = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign o_s    = w_s;
    assign o_rise = w_s & ~r_s_d;
    assign o_fall = ~w_s & r_s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with valid/ack result handshake and stuck-line
// timeout. Build with PWM_CAPTURE_FILTER_EN to add the input glitch filter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = PWM_CNT_W,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    input  logic             meas_ack,
    output logic             meas_ovr,
    output logic             timeout,
    output logic             stuck_lvl
);

    cap_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high_lat;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_ovr;
    logic             r_timeout;
    logic             r_stuck;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_max;
    logic             w_publish;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pwm  (pwm_in),
        .o_s    (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_cnt_max = &r_cnt;
    assign w_publish = w_rise && (r_state == ST_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_high_lat <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_timeout  <= 1'b0;
            r_stuck    <= 1'b0;
        end else if (!cap_en) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ovr     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_state <= ST_ARM;
            r_cnt   <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= CNT_W'(1);
            end else if (!w_cnt_max) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Timeout fires once per stuck episode so stuck_lvl keeps the
            // level seen when the line first stopped toggling.
            if (w_rise) begin
                r_timeout <= 1'b0;
                r_state   <= ST_HIGH;
            end else if (w_cnt_max && !r_timeout) begin
                r_timeout <= 1'b1;
                r_stuck   <= w_s;
                r_state   <= ST_ARM;
            end else if (w_fall && (r_state == ST_HIGH)) begin
                r_high_lat <= r_cnt;
                r_state    <= ST_LOW;
            end

            if (w_publish) begin
                r_period <= r_cnt;
                r_high   <= r_high_lat;
                r_valid  <= 1'b1;
                if (r_valid) begin
                    r_ovr <= !meas_ack;
                end
            end else if (meas_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign meas_period = r_period;
    assign meas_high   = r_high;
    assign meas_valid  = r_valid;
    assign meas_ovr    = r_ovr;
    assign timeout     = r_timeout;
    assign stuck_lvl   = r_stuck;

endmodule
